// File: rtl/fifo_burst_reader.sv
// Reads fixed-length bursts (or a full drain on flush) from a FIFO into a 2-entry stream buffer.
// Optional transfer counter on words_sent is enabled by defining FIFO_BURST_READER_CNT_EN.
module fifo_burst_reader #(
    parameter int width     = 32,
    parameter int burst_len = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             enable,
    input  logic             flush,
    input  logic [width-1:0] fifo_rd_data,
    input  logic             fifo_empty,
    input  logic             fifo_almost_empty,
    output logic             fifo_rd_en,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             flush_done,
    output logic [31:0]      words_sent
);

    localparam int CW = $clog2(burst_len + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(burst_len - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        FLUSH
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            done_nxt;
    logic            push, pop, push_last;

    logic [width-1:0] buf_data [2];
    logic             buf_last [2];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       occ;

    // Pop decision looks only at FIFO status and buffer room, never at out_ready.
    assign push       = (state != IDLE) && !fifo_empty && (occ < 2'd2);
    assign fifo_rd_en = push;
    assign out_valid  = (occ != 2'd0);
    assign pop        = out_valid && out_ready;
    assign out_data   = buf_data[rd_ptr];
    assign out_last   = buf_last[rd_ptr] & out_valid;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        push_last = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_almost_empty) begin
                    state_nxt = BURST;
                end else if (flush) begin
                    if (fifo_empty) done_nxt = 1'b1;
                    else            state_nxt = FLUSH;
                end
            end
            BURST: begin
                if (push) begin
                    if (cnt == LAST_CNT) begin
                        push_last = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (fifo_empty) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            flush_done <= done_nxt;
        end
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= fifo_rd_data;
                buf_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_BURST_READER_CNT_EN
    logic [31:0] sent_cnt;

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset)  sent_cnt <= '0;
        else if (pop)    sent_cnt <= sent_cnt + 32'd1;
    end

    assign words_sent = sent_cnt;
`else
    assign words_sent = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO model, scoreboard of expected stream words.
// Expected words_sent follows FIFO_BURST_READER_CNT_EN as defined for the build.
module tb_fifo_burst_reader;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         sync_reset = 1'b0;
    logic         enable = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] fifo_rd_data = '0;
    logic         fifo_empty = 1'b1;
    logic         fifo_almost_empty = 1'b1;
    logic         fifo_rd_en;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready = 1'b1;
    logic         flush_done;
    logic [31:0]  words_sent;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t         exp_q [$];
    logic [W-1:0] fifo_q [$];
    int           checks = 0;
    int           failures = 0;
    int           xfer_cnt = 0;
    int           pop_cnt = 0;
    bit           will_pop = 1'b0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.width(W), .burst_len(8)) dut (
        .clk               (clk),
        .sync_reset        (sync_reset),
        .enable            (enable),
        .flush             (flush),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_rd_en        (fifo_rd_en),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_last          (out_last),
        .out_ready         (out_ready),
        .flush_done        (flush_done),
        .words_sent        (words_sent)
    );

    task automatic fifo_refresh();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // Load n words first, first+1, ... into the FIFO; the first n_exp are expected on the stream.
    task automatic load(input logic [W-1:0] first, input int n, input int n_exp, input int last_idx);
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] v;
            exp_t e;
            v = first + W'(i);
            fifo_q.push_back(v);
            if (i < n_exp) begin
                e.data = v;
                e.last = (i == last_idx);
                exp_q.push_back(e);
            end
        end
        fifo_refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && out_valid === 1'b0 && fifo_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // FIFO model: pops one cycle's decision after the DUT has sampled the head word.
    always @(posedge clk) begin
        #1;
        if (will_pop) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pop_cnt++;
        end
        will_pop = 1'b0;
        fifo_refresh();
    end

    // Stream monitor: every transfer is checked against the scoreboard head.
    always @(negedge clk) begin
        will_pop = (fifo_rd_en === 1'b1);
        if (fifo_rd_en === 1'b1) begin
            checks++;
            if (fifo_empty) begin
                failures++;
                $display("FAIL pop_when_empty fifo_rd_en=%b fifo_empty=%b", fifo_rd_en, fifo_empty);
            end
        end
        if (sync_reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_extra got data=%0h last=%b expected no transfer", out_data, out_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_data !== e.data || out_last !== e.last) begin
                    failures++;
                    $display("FAIL scoreboard got data=%0h last=%b expected data=%0h last=%b",
                             out_data, out_last, e.data, e.last);
                end
            end
        end
    end

    task automatic test_reset();
        #3 sync_reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, fifo_rd_en, flush_done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b expected=0000", {out_valid, out_last, fifo_rd_en, flush_done});
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%0h expected=0", out_data);
        end
        checks++;
        if (words_sent !== 32'd0) begin
            failures++;
            $display("FAIL reset_words_sent got=%0d expected=0", words_sent);
        end
        repeat (2) @(posedge clk);
        #2 sync_reset = 1'b0;
    endtask

    task automatic test_burst();
        int base;
        base = xfer_cnt;
        fifo_almost_empty = 1'b0;
        out_ready = 1'b1;
        load(32'h1, 10, 8, 7);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 10 && out_valid !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL burst_consecutive word=%0d out_valid=%b expected=1", i, out_valid);
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt - base != 8) begin
            failures++;
            $display("FAIL burst_end out_valid=%b transfers=%0d expected out_valid=0 transfers=8",
                     out_valid, xfer_cnt - base);
        end
        checks++;
        if (fifo_q.size() != 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL burst_idle fifo_left=%0d exp_left=%0d expected fifo_left=2 exp_left=0",
                     fifo_q.size(), exp_q.size());
        end
        fifo_q.delete();
        fifo_refresh();
    endtask

    task automatic test_backpressure();
        int base, base_pop;
        logic [W-1:0] held;
        bit ok;
        base = xfer_cnt;
        held = '0;
        load(32'h11, 8, 8, 7);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 10 && out_valid !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b0;
        base_pop = pop_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) held = out_data;
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
                failures++;
                $display("FAIL stall_stable cycle=%0d data=%0h valid=%b expected data=%0h valid=1",
                         i, out_data, out_valid, held);
            end
            if (i >= 1) begin
                checks++;
                if (fifo_rd_en !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_rd_en cycle=%0d got=%b expected=0", i, fifo_rd_en);
                end
            end
        end
        checks++;
        if (pop_cnt - base_pop != 1) begin
            failures++;
            $display("FAIL stall_pops got=%0d expected=1", pop_cnt - base_pop);
        end
        tick();
        out_ready = 1'b1;
        wait_drain(40, ok);
        checks++;
        if (!ok || xfer_cnt - base != 8) begin
            failures++;
            $display("FAIL stall_drain drained=%b transfers=%0d expected drained=1 transfers=8",
                     ok, xfer_cnt - base);
        end
    endtask

    task automatic test_flush();
        int base, pulses, at_pulse;
        base = xfer_cnt;
        pulses = 0;
        at_pulse = -1;
        fifo_almost_empty = 1'b1;
        load(32'h21, 3, 3, -1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            if (flush_done === 1'b1) begin
                pulses++;
                at_pulse = xfer_cnt - base;
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL flush_pulse got=%0d cycles expected=1", pulses);
        end
        checks++;
        if (at_pulse != 3 || exp_q.size() != 0 || fifo_q.size() != 0) begin
            failures++;
            $display("FAIL flush_words at_pulse=%0d exp_left=%0d fifo_left=%0d expected 3/0/0",
                     at_pulse, exp_q.size(), fifo_q.size());
        end
    endtask

    task automatic test_flush_empty();
        int pulses;
        pulses = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (flush_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty pulses=%0d out_valid=%b expected pulses=1 out_valid=0",
                     pulses, out_valid);
        end
    endtask

    task automatic test_empty_stall();
        int base;
        bit ok;
        base = xfer_cnt;
        fifo_almost_empty = 1'b0;
        load(32'h31, 5, 5, -1);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 20 && fifo_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (fifo_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL empty_rd_en cycle=%0d got=%b expected=0", i, fifo_rd_en);
            end
        end
        tick();
        load(32'h36, 3, 3, 2);
        wait_drain(30, ok);
        checks++;
        if (!ok || xfer_cnt - base != 8) begin
            failures++;
            $display("FAIL empty_resume drained=%b transfers=%0d expected drained=1 transfers=8",
                     ok, xfer_cnt - base);
        end
    endtask

    task automatic test_reset_mid_burst();
        int base;
        bit ok;
        base = xfer_cnt;
        fifo_almost_empty = 1'b0;
        load(32'h41, 8, 8, 7);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 20 && xfer_cnt - base < 3; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #3 sync_reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, fifo_rd_en, flush_done} !== 4'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL midreset_outputs flags=%b data=%0h expected flags=0000 data=0",
                     {out_valid, out_last, fifo_rd_en, flush_done}, out_data);
        end
        exp_q.delete();
        fifo_q.delete();
        fifo_refresh();
        @(posedge clk);
        #3 sync_reset = 1'b0;
        tick();
        base = xfer_cnt;
        load(32'h51, 8, 8, 7);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_drain(30, ok);
        checks++;
        if (!ok || xfer_cnt - base != 8) begin
            failures++;
            $display("FAIL midreset_next_burst drained=%b transfers=%0d expected drained=1 transfers=8",
                     ok, xfer_cnt - base);
        end
    endtask

    task automatic test_words_sent();
        int base;
        bit ok;
        logic [31:0] exp_ws;
`ifdef FIFO_BURST_READER_CNT_EN
        exp_ws = 32'd20;
`else
        exp_ws = 32'd0;
`endif
        @(posedge clk);
        #3 sync_reset = 1'b1;
        @(posedge clk);
        #3 sync_reset = 1'b0;
        tick();
        base = xfer_cnt;
        fifo_almost_empty = 1'b1;
        load(32'h61, 20, 20, -1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_drain(60, ok);
        checks++;
        if (!ok || xfer_cnt - base != 20) begin
            failures++;
            $display("FAIL count_drain drained=%b transfers=%0d expected drained=1 transfers=20",
                     ok, xfer_cnt - base);
        end
        checks++;
        if (words_sent !== exp_ws) begin
            failures++;
            $display("FAIL words_sent got=%0d expected=%0d", words_sent, exp_ws);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_flush();
        test_flush_empty();
        test_empty_stall();
        test_reset_mid_burst();
        test_words_sent();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
